// File: rtl/fwd_scoreboard.sv
// Purpose: EX-stage operand forwarding select and load-use/multi-cycle hazard detection.
// Latency: fwd_sel_o/stall_o are combinational from scoreboard state; the scoreboard updates on each advance edge.
// Backpressure: adv_i=0 freezes all state; stall_o holds EX/upstream and injects a bubble at stage 1.
module fwd_scoreboard #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int LAT_W   = 3,
    parameter int CNT_W   = 16,
    localparam int SELW   = $clog2(DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      adv_i,
    input  logic                      flush_i,
    input  logic                      ex_valid_i,
    input  logic                      ex_we_i,
    input  logic [REG_AW-1:0]         ex_rd_i,
    input  logic [LAT_W-1:0]          ex_lat_i,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs_i,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel_o,
    output logic                      stall_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    // Scoreboard entry index i holds post-EX stage i+1 (index 0 = EX/MEM).
    logic              v_q   [DEPTH];
    logic [REG_AW-1:0] rd_q  [DEPTH];
    logic [LAT_W-1:0]  cnt_q [DEPTH];
    logic              v_d   [DEPTH];
    logic [REG_AW-1:0] rd_d  [DEPTH];
    logic [LAT_W-1:0]  cnt_d [DEPTH];
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    logic [NUM_SRC-1:0] busy;
    logic [LAT_W-1:0]   lat_clamp;
    logic               bubble;

    // Per source: youngest matching stage wins; busy if that producer is not ready yet.
    always_comb begin
        fwd_sel_o = '0;
        busy      = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (v_q[k-1] && (rd_q[k-1] == ex_rs_i[j*REG_AW +: REG_AW])) begin
                    fwd_sel_o[j*SELW +: SELW] = SELW'(k);
                    busy[j]                   = (cnt_q[k-1] != '0);
                end
            end
        end
        stall_o = ex_valid_i && !flush_i && (|busy);
    end

    // Latency clamp into [1, DEPTH]; results later than the window are treated as ready at its end.
    always_comb begin
        lat_clamp = ex_lat_i;
        if (ex_lat_i == '0) begin
            lat_clamp = LAT_W'(1);
        end else if (32'(ex_lat_i) > DEPTH) begin
            lat_clamp = LAT_W'(DEPTH);
        end
    end

    // Next state: shift with saturating countdown on advance, hold otherwise.
    always_comb begin
        bubble      = stall_o || flush_i || !ex_valid_i;
        v_d         = v_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (adv_i) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                v_d[k]   = v_q[k-1];
                rd_d[k]  = rd_q[k-1];
                cnt_d[k] = (cnt_q[k-1] == '0) ? '0 : cnt_q[k-1] - LAT_W'(1);
            end
            if (bubble) begin
                v_d[0]   = 1'b0;
                rd_d[0]  = '0;
                cnt_d[0] = '0;
            end else begin
                v_d[0]   = ex_we_i && (ex_rd_i != '0);
                rd_d[0]  = ex_rd_i;
                cnt_d[0] = lat_clamp - LAT_W'(1);
            end
            if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset dominates advance and flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                v_q[k]   <= 1'b0;
                rd_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
